// File: rtl/sort_pkg.sv
// ============================================================================
// sort_pkg : widths and constants shared by the insertion sorter and framer
// Rev 1.0
// ============================================================================
`default_nettype none

package sort_pkg;

    localparam int SORT_DATA_WIDTH  = 32;
    localparam int SORT_FRAME_LEN   = 10;
    localparam int SORT_IN_CNT_W    = $clog2(SORT_FRAME_LEN);
    localparam int SORT_FRAME_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/sort_sync_fifo.sv
// ============================================================================
// sort_sync_fifo : single-clock FIFO, no bypass, head entry exposed directly
// Rev 1.0
// ============================================================================
`default_nettype none

module sort_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [c_AW:0]      r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW:0]      r_rd_ptr_q, w_rd_ptr_d;
    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [WIDTH-1:0]   w_mem_d [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr_q == r_rd_ptr_q);
    assign o_full  = (r_wr_ptr_q[c_AW] != r_rd_ptr_q[c_AW]) &&
                     (r_wr_ptr_q[c_AW-1:0] == r_rd_ptr_q[c_AW-1:0]);
    assign o_head  = r_mem_q[r_rd_ptr_q[c_AW-1:0]];

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_mem_d    = r_mem_q;
        if (i_push && !o_full) begin
            w_mem_d[r_wr_ptr_q[c_AW-1:0]] = i_din;
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
        end
        if (i_pop && !o_empty) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_mem_q    <= w_mem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sort_out_framer.sv
// ============================================================================
// sort_out_framer : buffers sorted words, tags frame ends with sm_tlast.
// Option macro SORT_FRAMER_ORDER_CHECK_EN enables the ascending-order checker.
// Rev 1.0
// ============================================================================
`default_nettype none

module sort_out_framer
    import sort_pkg::*;
#(
    parameter int pDATA_WIDTH = SORT_DATA_WIDTH,
    parameter int pFRAME_LEN  = SORT_FRAME_LEN,
    parameter int pDEPTH      = 4
) (
    input  logic                        axis_clk,
    input  logic                        axis_rst,
    input  logic                        ss_tvalid,
    output logic                        ss_tready,
    input  logic [pDATA_WIDTH-1:0]      ss_tdata,
    output logic                        sm_tvalid,
    input  logic                        sm_tready,
    output logic [pDATA_WIDTH-1:0]      sm_tdata,
    output logic                        sm_tlast,
    output logic                        frame_done,
    output logic [SORT_FRAME_CNT_W-1:0] frame_cnt,
    output logic                        order_err,
    input  logic                        clear_err
);

    localparam int c_IN_CNT_W = $clog2(pFRAME_LEN);
    localparam logic [c_IN_CNT_W-1:0] c_IN_LAST = c_IN_CNT_W'(pFRAME_LEN - 1);
    localparam logic [c_IN_CNT_W-1:0] c_IN_ONE  = {{(c_IN_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SORT_FRAME_CNT_W-1:0] c_FCNT_ONE =
        {{(SORT_FRAME_CNT_W-1){1'b0}}, 1'b1};

    logic                        r_rdy_q, w_rdy_d;
    logic [c_IN_CNT_W-1:0]       r_in_cnt_q, w_in_cnt_d;
    logic [SORT_FRAME_CNT_W-1:0] r_frame_cnt_q, w_frame_cnt_d;
    logic                        r_frame_done_q, w_frame_done_d;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_in_last;
    logic                        w_full;
    logic                        w_empty;
    logic [pDATA_WIDTH:0]        w_head;

    // r_rdy_q holds ss_tready low through reset and until the first edge after.
    assign w_rdy_d    = 1'b1;
    assign ss_tready  = r_rdy_q && !w_full;
    assign sm_tvalid  = !w_empty;
    assign sm_tdata   = w_head[pDATA_WIDTH-1:0];
    assign sm_tlast   = w_head[pDATA_WIDTH];
    assign frame_done = r_frame_done_q;
    assign frame_cnt  = r_frame_cnt_q;

    assign w_push    = ss_tvalid && ss_tready;
    assign w_pop     = sm_tvalid && sm_tready;
    assign w_in_last = (r_in_cnt_q == c_IN_LAST);

    sort_sync_fifo #(
        .WIDTH (pDATA_WIDTH + 1),
        .DEPTH (pDEPTH)
    ) u_fifo (
        .clk     (axis_clk),
        .rst     (axis_rst),
        .i_push  (w_push),
        .i_din   ({w_in_last, ss_tdata}),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_comb begin
        w_in_cnt_d     = r_in_cnt_q;
        w_frame_cnt_d  = r_frame_cnt_q;
        w_frame_done_d = w_pop && sm_tlast;
        if (w_push) begin
            w_in_cnt_d = w_in_last ? '0 : (r_in_cnt_q + c_IN_ONE);
        end
        if (w_pop && sm_tlast) begin
            w_frame_cnt_d = r_frame_cnt_q + c_FCNT_ONE;
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_rdy_q        <= 1'b0;
            r_in_cnt_q     <= '0;
            r_frame_cnt_q  <= '0;
            r_frame_done_q <= 1'b0;
        end else begin
            r_rdy_q        <= w_rdy_d;
            r_in_cnt_q     <= w_in_cnt_d;
            r_frame_cnt_q  <= w_frame_cnt_d;
            r_frame_done_q <= w_frame_done_d;
        end
    end

`ifdef SORT_FRAMER_ORDER_CHECK_EN
    logic [pDATA_WIDTH-1:0] r_prev_q, w_prev_d;
    logic                   r_err_q, w_err_d;

    // Word 0 of a frame starts a new ascending run, so it is never compared.
    always_comb begin
        w_prev_d = r_prev_q;
        w_err_d  = r_err_q;
        if (clear_err) begin
            w_err_d = 1'b0;
        end
        if (w_push) begin
            w_prev_d = ss_tdata;
            if ((r_in_cnt_q != '0) && (ss_tdata < r_prev_q)) begin
                w_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_prev_q <= '0;
            r_err_q  <= 1'b0;
        end else begin
            r_prev_q <= w_prev_d;
            r_err_q  <= w_err_d;
        end
    end

    assign order_err = r_err_q;
`else
    logic w_unused_clear_err;
    assign w_unused_clear_err = clear_err;
    assign order_err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sort_out_framer.sv
// ============================================================================
// tb_sort_out_framer : directed self-checking bench for sort_out_framer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sort_out_framer;

    logic        axis_clk = 1'b0;
    logic        axis_rst = 1'b1;
    logic        ss_tvalid = 1'b0;
    logic        ss_tready;
    logic [31:0] ss_tdata = '0;
    logic        sm_tvalid;
    logic        sm_tready = 1'b0;
    logic [31:0] sm_tdata;
    logic        sm_tlast;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        order_err;
    logic        clear_err = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_data[$];
    bit          q_last[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_cyc = -1;
    bit          pushing_done = 1'b0;

    always #5 axis_clk = ~axis_clk;

    sort_out_framer dut (
        .axis_clk   (axis_clk),
        .axis_rst   (axis_rst),
        .ss_tvalid  (ss_tvalid),
        .ss_tready  (ss_tready),
        .ss_tdata   (ss_tdata),
        .sm_tvalid  (sm_tvalid),
        .sm_tready  (sm_tready),
        .sm_tdata   (sm_tdata),
        .sm_tlast   (sm_tlast),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .order_err  (order_err),
        .clear_err  (clear_err)
    );

    // Output monitor: records every transfer and frame_done pulse.
    always @(posedge axis_clk) begin
        cyc++;
        if (sm_tvalid && sm_tready) begin
            q_data.push_back(sm_tdata);
            q_last.push_back(sm_tlast);
            if (sm_tlast) last_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        int n = 0;
        ss_tvalid = 1'b1;
        ss_tdata  = d;
        while (!ss_tready && n < 50) begin
            step();
            n++;
        end
        if (!ss_tready) check_eq("push_timeout", {31'd0, ss_tready}, 32'd1);
        step();
        ss_tvalid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int n, input int base);
        check_eq({tag, "_count"}, q_data.size(), n);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            check_eq({tag, "_data"}, q_data[i], base + i);
            check_eq({tag, "_last"}, {31'd0, q_last[i]}, {31'd0, (i % 10) == 9});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {27'd0, ss_tready, sm_tvalid, sm_tlast, frame_done, order_err}, 32'd0);
        check_eq({tag, "_data"}, sm_tdata, 32'd0);
        check_eq({tag, "_fcnt"}, {16'd0, frame_cnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and ready release
        repeat (3) step();
        check_all_zero("reset");
        axis_rst = 1'b0;
        #1;
        check_eq("tready_pre_edge", {31'd0, ss_tready}, 32'd0);
        step();
        check_eq("tready_post_edge", {31'd0, ss_tready}, 32'd1);

        // Single frame 1..10, sink always ready
        sm_tready = 1'b1;
        for (int i = 1; i <= 10; i++) push_word(i);
        repeat (5) step();
        check_frame("single", 10, 1);
        check_eq("single_done_cnt", done_cnt, 1);
        check_eq("single_done_lat", done_cyc, last_cyc + 1);
        check_eq("single_fcnt", {16'd0, frame_cnt}, 32'd1);

        // Backpressure: 6 words offered with sink stalled
        q_data.delete(); q_last.delete();
        sm_tready = 1'b0;
        push_word(101); push_word(102); push_word(103);
        check_eq("bp_tready_3", {31'd0, ss_tready}, 32'd1);
        push_word(104);
        check_eq("bp_tready_full", {31'd0, ss_tready}, 32'd0);
        check_eq("bp_head_valid", {31'd0, sm_tvalid}, 32'd1);
        ss_tvalid = 1'b1;
        ss_tdata  = 105;
        repeat (3) step();
        check_eq("bp_stall_data", sm_tdata, 32'd101);
        check_eq("bp_stall_tready", {31'd0, ss_tready}, 32'd0);
        check_eq("bp_no_output", q_data.size(), 0);
        sm_tready = 1'b1;
        step();
        check_eq("bp_tready_rise", {31'd0, ss_tready}, 32'd1);
        push_word(105);
        push_word(106);
        repeat (8) step();
        check_eq("bp_count", q_data.size(), 6);
        for (int i = 0; i < 6 && i < q_data.size(); i++) begin
            check_eq("bp_data", q_data[i], 101 + i);
            check_eq("bp_last", {31'd0, q_last[i]}, 32'd0);
        end

        // Mid-frame reset with words still queued
        sm_tready = 1'b0;
        push_word(301); push_word(302); push_word(303);
        check_eq("mid_valid", {31'd0, sm_tvalid}, 32'd1);
        #2 axis_rst = 1'b1;
        #1;
        check_all_zero("mid_rst_async");
        step(); step();
        check_all_zero("mid_rst_hold");
        axis_rst = 1'b0;
        step();
        q_data.delete(); q_last.delete();
        done_cnt = 0;
        sm_tready = 1'b1;
        for (int i = 0; i < 10; i++) push_word(200 + i);
        repeat (5) step();
        check_frame("post_rst", 10, 200);
        check_eq("post_rst_fcnt", {16'd0, frame_cnt}, 32'd1);
        check_eq("post_rst_done", done_cnt, 1);

        // Back-to-back frames 0..29 with random sink readiness
        q_data.delete(); q_last.delete();
        done_cnt = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) push_word(i);
                pushing_done = 1'b1;
            end
            begin
                while (!pushing_done) begin
                    sm_tready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        sm_tready = 1'b1;
        repeat (40) step();
        check_frame("b2b", 30, 0);
        check_eq("b2b_done_cnt", done_cnt, 3);
        check_eq("b2b_fcnt", {16'd0, frame_cnt}, 32'd4);

`ifdef SORT_FRAMER_ORDER_CHECK_EN
        // Order checker: 5,7,3 breaks ascending order on word 2
        push_word(5); push_word(7);
        check_eq("ord_before", {31'd0, order_err}, 32'd0);
        push_word(3);
        check_eq("ord_set", {31'd0, order_err}, 32'd1);
        for (int i = 4; i <= 10; i++) push_word(i);
        check_eq("ord_sticky", {31'd0, order_err}, 32'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check_eq("ord_clear", {31'd0, order_err}, 32'd0);
        for (int i = 9; i <= 18; i++) push_word(i);
        for (int i = 1; i <= 10; i++) push_word(i);
        check_eq("ord_frame_boundary", {31'd0, order_err}, 32'd0);
`else
        // Without the checker an out-of-order frame raises nothing
        push_word(10); push_word(2); push_word(8);
        check_eq("noord_err", {31'd0, order_err}, 32'd0);
        for (int i = 1; i <= 7; i++) push_word(i);
        check_eq("noord_err_end", {31'd0, order_err}, 32'd0);
`endif
        repeat (10) step();
        check_eq("final_empty", {31'd0, sm_tvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sort_out_framer.md
# sort_out_framer

Downstream stage of the 10-word insertion sorter. It accepts the sorted word stream the sorter emits, buffers it in a small FIFO, and marks the last word of every frame with `sm_tlast` for the user DMA write channel. Under a compile option it also checks that each frame arrives in ascending order. It sits between the sorter's master stream port and the DMA stream-to-memory path.

## Interface
- `pDATA_WIDTH`, 32, stream word width.
- `pFRAME_LEN`, 10, words per sorted frame; range 2..255.
- `pDEPTH`, 4, FIFO entries; power of two, at least 2.
- `axis_clk` input 1: single clock; all logic on the rising edge.
- `axis_rst` input 1: reset is asynchronous and active-high.
- `ss_tvalid` input 1: sorter word valid.
- `ss_tready` output 1: framer can accept a word.
- `ss_tdata` input pDATA_WIDTH: sorted word from the sorter.
- `sm_tvalid` output 1: FIFO head is valid toward the DMA.
- `sm_tready` input 1: DMA accepts the head word.
- `sm_tdata` output pDATA_WIDTH: head word.
- `sm_tlast` output 1: head word is the last word of its frame.
- `frame_done` output 1: one-cycle pulse after a tlast word transfers out.
- `frame_cnt` output 16: count of frames fully transferred out; wraps modulo 2^16.
- `order_err` output 1: sticky error, set when a frame is out of order.
- `clear_err` input 1: synchronous clear for `order_err`.

## Operation
- Push: a word is accepted when `ss_tvalid & ss_tready`. `ss_tready = !full`. There is no bypass, so a full FIFO never accepts a word, even in a cycle where a pop also occurs.
- Each FIFO entry stores {last, data}. `last` = (`in_cnt == pFRAME_LEN-1`).
- `in_cnt` counts accepted words. It starts at 0, increments on each push, and wraps to 0 after the last word of a frame.
- Pop: a word leaves when `sm_tvalid & sm_tready`. `sm_tvalid = !empty`. `sm_tdata` and `sm_tlast` come straight from the head entry.
- While `sm_tvalid=1` and `sm_tready=0`, the head data and last flag stay stable.
- Push and pop in the same cycle (FIFO not full) leave the occupancy unchanged.
- Pointers are log2(pDEPTH)+1 bits wide.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the lower bits are equal.
  - Pointers wrap naturally.
- Popping an entry with `last=1`:
  - `frame_cnt` increments.
  - `frame_done` is asserted on the next cycle for exactly one cycle.
- Frames are delimited only by count. Back-to-back frames need no idle gap.

## Timing
- All outputs during and after reset are 0: `ss_tready`, `sm_tvalid`, `sm_tdata`, `sm_tlast`, `frame_done`, `frame_cnt`, `order_err`.
- `ss_tready` becomes 1 on the first clock edge after reset deasserts.
- Latency: a word accepted at edge N is visible at `sm_*` after edge N, so it can transfer out at edge N+1.
- Sustained throughput is 1 word/cycle when `sm_tready` is held high.
- Full-depth fill with `sm_tready=0`: `ss_tready` drops in the cycle after the pDEPTH-th push.
- Full-depth fill with `sm_tready=0`: `ss_tready` rises in the cycle after the first pop.
- Reset asserted mid-frame clears immediately, asynchronously:
  - FIFO contents, `in_cnt`, `frame_cnt`, `order_err`.
  - Any partial frame is discarded.
  - The next accepted word is word 0 of a new frame.
- If `clear_err` and a new error arrive in the same cycle, set wins.

## Configuration
- Macro `SORT_FRAMER_ORDER_CHECK_EN`.
- Defined:
  - The framer registers the previously pushed word.
  - Each pushed word with `in_cnt != 0` is compared unsigned against it.
  - If new < previous, `order_err` sets on that edge and holds until `clear_err` or reset.
  - Word 0 of each frame is never compared.
  - Equal values are legal.
- Not defined: the compare logic is absent, `order_err` is tied to 0, and `clear_err` is ignored. The port list is identical either way.

## Structure
- Shared package `sort_pkg`:
  - `SORT_DATA_WIDTH=32` and `SORT_FRAME_LEN=10`, also used by the sorter.
  - The counter width for `in_cnt`, derived as clog2(SORT_FRAME_LEN).
  - The `frame_cnt` width constant.
- Sub-module `sort_sync_fifo`: parameterised width/depth, async active-high reset, with push/pop/full/empty/head ports.
- The framer keeps only `in_cnt`, `frame_cnt`, `frame_done` and the order checker.

## Test plan
- Single frame: push 10 words 1..10 with `sm_tready=1`.
  - 10 outputs equal 1..10.
  - `sm_tlast` only on word 10.
  - `frame_done` pulses one cycle later.
  - `frame_cnt=1`.
- Backpressure: `sm_tready=0` while 6 words are offered.
  - `ss_tready` falls after 4 pushes.
  - Raise `sm_tready`: all 6 words emerge in order with no loss or duplication.
  - `sm_tdata` stays stable while stalled.
- Back-to-back: 3 frames with data 0..29 pushed continuously, with random `sm_tready`.
  - tlast appears on values 9, 19 and 29.
  - `frame_cnt=3`.
  - Exactly 3 `frame_done` pulses.
- Order check (macro defined): frame 5,7,3,...
  - `order_err` = 1 after word 3 is pushed and stays 1.
  - `clear_err` pulse returns it to 0.
  - Frame 9,…(last) followed by frame 1,… gives no error.
- Mid-frame reset: push 4 words, assert `axis_rst` for 2 cycles.
  - All outputs are 0 during reset.
  - The next 10 pushed words form one complete frame with tlast on the 10th.
- Macro undefined: out-of-order frame 10,2,8 → `order_err` stays 0.
